// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame types, parity modes and parity helper
//
// Contents:
//   tx_state_t  transmit frame states (IDLE, START, DATA, PARITY, STOP)
//   PAR_*       parity-mode encodings carried on the 2-bit mode field
//   parity_bit  parity value for a data word; also used by the receiver
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  localparam logic [1:0] PAR_MARK = 2'd3;

  // Words narrower than 9 bits are zero-extended by the caller.
  // Zero-extension does not change the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
    case (mode)
      PAR_EVEN: parity_bit = ^data;
      PAR_ODD:  parity_bit = ~(^data);
      PAR_MARK: parity_bit = 1'b1;
      default:  parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_holding_reg.sv
// rtl/uart_tx_holding_reg.sv - one-word data+mode buffer in front of the UART shifter
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   wr             write strobe
//   wr_data        word to capture
//   wr_mode        parity mode to capture
//   drain          frame engine takes the held word on this edge
//   valid          buffer holds a word
//   valid_next     value valid takes at the next edge
//   data, mode     held word and its parity mode
//   overrun        one-clk pulse when a write is dropped
module uart_tx_holding_reg
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_mode,
  input  logic              drain,
  output logic              valid,
  output logic              valid_next,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        mode,
  output logic              overrun
);

  logic accept;

  // A write that lands on the draining edge refills the buffer directly.
  assign accept     = wr & (~valid | drain);
  assign valid_next = accept | (valid & ~drain);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid   <= 1'b0;
      data    <= '0;
      mode    <= PAR_NONE;
      overrun <= 1'b0;
    end else begin
      valid   <= valid_next;
      overrun <= wr & valid & ~drain;
      if (accept) begin
        data <= wr_data;
        mode <= wr_mode;
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART transmitter with one-word holding register
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous active-low reset
//   Tx_sample_ENABLE  oversampling tick, OVERSAMPLE per bit period
//   Tx_WR             write strobe; samples Tx_DATA and Tx_PARITY_MODE
//   Tx_DATA           word to send, LSB first
//   Tx_PARITY_MODE    0 none, 1 even, 2 odd, 3 mark
//   TxD               serial line, idles high
//   Tx_BUSY           frame in flight or word held
//   Tx_READY          holding register empty
//   Tx_DONE           one-clk pulse at end of last stop bit
//   Tx_OVERRUN        one-clk pulse when a write is dropped
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Tx_sample_ENABLE,
  input  logic              Tx_WR,
  input  logic [DATA_W-1:0] Tx_DATA,
  input  logic [1:0]        Tx_PARITY_MODE,
  output logic              TxD,
  output logic              Tx_BUSY,
  output logic              Tx_READY,
  output logic              Tx_DONE,
  output logic              Tx_OVERRUN
);

  localparam int CW = $clog2(OVERSAMPLE) + 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9 || (STOP_BITS != 1 && STOP_BITS != 2) || OVERSAMPLE < 1)
  begin : g_param_check
    $error("uart_tx_frame: illegal DATA_W, STOP_BITS or OVERSAMPLE");
  end

  tx_state_t         state;
  logic [CW-1:0]     tick_cnt;
  logic [3:0]        bit_idx;
  logic [DATA_W-1:0] shifter;
  logic [1:0]        par_mode;
  logic              par_bit;

  logic              hold_valid;
  logic              hold_valid_next;
  logic [DATA_W-1:0] hold_data;
  logic [1:0]        hold_mode;
  logic              bit_end;
  logic              stop_end;
  logic              drain;

  // bit_end: the tick that closes the current bit period.
  assign bit_end  = (state != IDLE) & Tx_sample_ENABLE & (tick_cnt == TICK_LAST);
  assign stop_end = (state == STOP) & bit_end & (bit_idx == STOP_LAST);
  assign drain    = hold_valid & ((state == IDLE) | stop_end);
  assign Tx_READY = ~hold_valid;

  uart_tx_holding_reg #(.DATA_W(DATA_W)) u_hold (
    .clk        (clk),
    .reset      (reset),
    .wr         (Tx_WR),
    .wr_data    (Tx_DATA),
    .wr_mode    (Tx_PARITY_MODE),
    .drain      (drain),
    .valid      (hold_valid),
    .valid_next (hold_valid_next),
    .data       (hold_data),
    .mode       (hold_mode),
    .overrun    (Tx_OVERRUN)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      par_mode <= PAR_NONE;
      par_bit  <= 1'b0;
      TxD      <= 1'b1;
      Tx_BUSY  <= 1'b0;
      Tx_DONE  <= 1'b0;
    end else begin
      Tx_DONE <= 1'b0;
      Tx_BUSY <= 1'b1;
      // Ticks in IDLE (including the load edge) are not counted.
      if (state != IDLE && Tx_sample_ENABLE)
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (hold_valid) begin
            state    <= START;
            shifter  <= hold_data;
            par_mode <= hold_mode;
            par_bit  <= parity_bit(9'(hold_data), hold_mode);
            TxD      <= 1'b0;
          end else begin
            Tx_BUSY <= hold_valid_next;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            TxD     <= shifter[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (par_mode != PAR_NONE) begin
                state <= PARITY;
                TxD   <= par_bit;
              end else begin
                state <= STOP;
                TxD   <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shifter <= shifter >> 1;
              TxD     <= shifter[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            bit_idx <= '0;
            TxD     <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_idx == STOP_LAST) begin
              Tx_DONE <= 1'b1;
              bit_idx <= '0;
              // A pending word starts right away: no idle bit time between frames.
              if (hold_valid) begin
                state    <= START;
                shifter  <= hold_data;
                par_mode <= hold_mode;
                par_bit  <= parity_bit(9'(hold_data), hold_mode);
                TxD      <= 1'b0;
              end else begin
                state   <= IDLE;
                Tx_BUSY <= hold_valid_next;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed self-checking bench for uart_tx_frame
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       tick_div = 1'b0;

  logic       wr1 = 1'b0;
  logic [7:0] data1 = '0;
  logic [1:0] mode1 = '0;
  logic       txd1, busy1, ready1, done1, ovr1;

  logic       wr2 = 1'b0;
  logic [6:0] data2 = '0;
  logic [1:0] mode2 = '0;
  logic       txd2, busy2, ready2, done2, ovr2;

  logic       sel = 1'b0;
  logic       m_txd, m_busy, m_ready, m_done, m_ovr;

  int n_checks = 0;
  int n_fail = 0;

  uart_tx_frame dut1 (
    .clk              (clk),
    .reset            (reset),
    .Tx_sample_ENABLE (tick),
    .Tx_WR            (wr1),
    .Tx_DATA          (data1),
    .Tx_PARITY_MODE   (mode1),
    .TxD              (txd1),
    .Tx_BUSY          (busy1),
    .Tx_READY         (ready1),
    .Tx_DONE          (done1),
    .Tx_OVERRUN       (ovr1)
  );

  uart_tx_frame #(.DATA_W(7), .STOP_BITS(2), .OVERSAMPLE(16)) dut2 (
    .clk              (clk),
    .reset            (reset),
    .Tx_sample_ENABLE (tick),
    .Tx_WR            (wr2),
    .Tx_DATA          (data2),
    .Tx_PARITY_MODE   (mode2),
    .TxD              (txd2),
    .Tx_BUSY          (busy2),
    .Tx_READY         (ready2),
    .Tx_DONE          (done2),
    .Tx_OVERRUN       (ovr2)
  );

  assign m_txd   = sel ? txd2   : txd1;
  assign m_busy  = sel ? busy2  : busy1;
  assign m_ready = sel ? ready2 : ready1;
  assign m_done  = sel ? done2  : done1;
  assign m_ovr   = sel ? ovr2   : ovr1;

  always #5 clk = ~clk;

  // Oversampling tick on every other clock; changes away from the rising edge.
  always @(negedge clk) begin
    tick_div = ~tick_div;
    tick = tick_div;
  end

  task automatic do_write(input logic s, input logic [8:0] d, input logic [1:0] m);
    if (s) begin
      data2 = d[6:0]; mode2 = m; wr2 = 1'b1;
    end else begin
      data1 = d[7:0]; mode1 = m; wr1 = 1'b1;
    end
    @(posedge clk); #1;
    wr1 = 1'b0; wr2 = 1'b0;
    // Scramble the mode input so a mid-frame change would corrupt parity.
    mode1 = ~m; mode2 = ~m;
  endtask

  // Called at E0+#1 (or later with ticks0 already counted since the start edge).
  // exp_bits is LSB-first line content sampled mid-bit.
  task automatic monitor(input string name, input logic [31:0] exp_bits, input int nbits,
                         input int exp_t1, input int exp_t2, input bit check_e1, input int ticks0);
    int ticks;
    int dones;
    int t1;
    int t2;
    logic [31:0] got;
    logic busy_last;
    ticks = ticks0; dones = 0; t1 = -1; t2 = -1; got = '0; busy_last = 1'b1;
    if (check_e1) begin
      @(posedge clk); #1;
      n_checks++;
      if (m_txd !== 1'b0) begin
        n_fail++; $display("FAIL %s start_at_E1: TxD=%b expected 0", name, m_txd);
      end
    end
    for (int cyc = 0; cyc < 3000 && ticks < nbits * 16 + 8; cyc++) begin
      @(posedge clk); #1;
      if (tick) begin
        ticks++;
        if (ticks % 16 == 8 && ticks / 16 < nbits) got[ticks / 16] = m_txd;
      end
      if (m_done === 1'b1) begin
        dones++;
        if (dones == 1) t1 = ticks; else t2 = ticks;
        busy_last = m_busy;
      end
    end
    n_checks++;
    if (ticks < nbits * 16 + 8) begin
      n_fail++; $display("FAIL %s timeout: ticks=%0d expected %0d", name, ticks, nbits * 16 + 8);
    end
    n_checks++;
    if (got !== exp_bits) begin
      n_fail++; $display("FAIL %s line_bits: got %b expected %b", name, got, exp_bits);
    end
    n_checks++;
    if (t1 != exp_t1) begin
      n_fail++; $display("FAIL %s done1_ticks: got %0d expected %0d", name, t1, exp_t1);
    end
    if (exp_t2 > 0) begin
      n_checks++;
      if (t2 != exp_t2) begin
        n_fail++; $display("FAIL %s done2_ticks: got %0d expected %0d", name, t2, exp_t2);
      end
    end
    n_checks++;
    if (dones != ((exp_t2 > 0) ? 2 : 1)) begin
      n_fail++; $display("FAIL %s done_count: got %0d expected %0d", name, dones, (exp_t2 > 0) ? 2 : 1);
    end
    n_checks++;
    if (busy_last !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_at_done: got %b expected 0", name, busy_last);
    end
    n_checks++;
    if (m_txd !== 1'b1 || m_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s idle_after: TxD=%b READY=%b expected 1 1", name, m_txd, m_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({txd1, busy1, ready1, done1, ovr1} !== 5'b10100) begin
      n_fail++; $display("FAIL reset_dut1: got %b expected 10100", {txd1, busy1, ready1, done1, ovr1});
    end
    n_checks++;
    if ({txd2, busy2, ready2, done2, ovr2} !== 5'b10100) begin
      n_fail++; $display("FAIL reset_dut2: got %b expected 10100", {txd2, busy2, ready2, done2, ovr2});
    end
    reset = 1'b1;
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (txd1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b1 || done1 !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_even();
    sel = 1'b0;
    do_write(1'b0, 9'h0A5, 2'd1);
    n_checks++;
    if (ready1 !== 1'b0 || busy1 !== 1'b1) begin
      n_fail++; $display("FAIL even_E0: READY=%b BUSY=%b expected 0 1", ready1, busy1);
    end
    monitor("even_A5", 32'({1'b1, 1'b0, 8'b10100101, 1'b0}), 11, 176, 0, 1'b1, 0);
  endtask

  task automatic test_odd_and_none();
    sel = 1'b0;
    do_write(1'b0, 9'h0A5, 2'd2);
    monitor("odd_A5", 32'({1'b1, 1'b1, 8'b10100101, 1'b0}), 11, 176, 0, 1'b1, 0);
    do_write(1'b0, 9'h007, 2'd0);
    monitor("none_07", 32'({1'b1, 8'b00000111, 1'b0}), 10, 160, 0, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    int t0;
    sel = 1'b0;
    t0 = 0;
    do_write(1'b0, 9'h03C, 2'd0);
    // Second write lands on the edge the first word drains into the shifter.
    data1 = 8'hC3; mode1 = 2'd0; wr1 = 1'b1;
    @(posedge clk); #1;
    wr1 = 1'b0;
    n_checks++;
    if (txd1 !== 1'b0 || ready1 !== 1'b0 || ovr1 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_write: TxD=%b READY=%b OVR=%b expected 0 0 0", txd1, ready1, ovr1);
    end
    data1 = 8'hFF; wr1 = 1'b1;
    @(posedge clk); #1;
    wr1 = 1'b0;
    if (tick) t0++;
    n_checks++;
    if (ovr1 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_overrun_pulse: got %b expected 1", ovr1);
    end
    @(posedge clk); #1;
    if (tick) t0++;
    n_checks++;
    if (ovr1 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_overrun_width: got %b expected 0", ovr1);
    end
    monitor("b2b_3C_C3", 32'({1'b1, 8'b11000011, 1'b0, 1'b1, 8'b00111100, 1'b0}), 20, 160, 320, 1'b0, t0);
  endtask

  task automatic test_two_stop();
    sel = 1'b1;
    do_write(1'b1, 9'h055, 2'd3);
    monitor("w7_s2_mark_55", 32'({2'b11, 1'b1, 7'b1010101, 1'b0}), 11, 176, 0, 1'b1, 0);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int ticks;
    sel = 1'b0;
    ticks = 0;
    do_write(1'b0, 9'h000, 2'd0);
    for (int cyc = 0; cyc < 1000 && ticks < 104; cyc++) begin
      @(posedge clk); #1;
      if (tick) ticks++;
    end
    n_checks++;
    if (ticks != 104 || txd1 !== 1'b0) begin
      n_fail++; $display("FAIL midframe_reach: ticks=%0d TxD=%b expected 104 0", ticks, txd1);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (txd1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b1) begin
      n_fail++; $display("FAIL midframe_abort: TxD=%b BUSY=%b READY=%b expected 1 0 1", txd1, busy1, ready1);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_write(1'b0, 9'h0A5, 2'd1);
    monitor("after_reset_A5", 32'({1'b1, 1'b0, 8'b10100101, 1'b0}), 11, 176, 0, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_even();
    test_odd_and_none();
    test_back_to_back();
    test_two_stop();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
